// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and latched-operation record.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_NOTA = 3'd5;
  localparam logic [2:0] OP_NAND = 3'd6;
  localparam logic [2:0] OP_NOR  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic       owner;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } op_t;

endpackage

// File: rtl/ALU_4bit.sv
// Purpose: 4-bit combinational ALU with zero and carry/borrow flags.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module ALU_4bit
  import alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] op,
  output logic [3:0] result,
  output logic       zero,
  output logic       carry
);

  logic [4:0] sum5;
  logic [4:0] dif5;

  assign sum5 = {1'b0, a} + {1'b0, b};
  // Bit 4 of the 5-bit difference is set exactly when a < b, i.e. the borrow.
  assign dif5 = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = 4'd0;
    carry  = 1'b0;
    case (op)
      OP_ADD:  {carry, result} = sum5;
      OP_SUB:  {carry, result} = dif5;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOTA: result = ~a;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      default: result = 4'd0;
    endcase
  end

  assign zero = (result == 4'd0);

endmodule

// File: rtl/alu_arbiter_ctrl.sv
// Purpose: round-robin arbitration of two requesters onto one shared ALU.
// Latency: accept in cycle N, registered result valid in cycle N+2.
// Backpressure: result held in RESP until the owner's rsp_ready; no new accepts meanwhile.
module alu_arbiter_ctrl
  import alu_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [4*NREQ-1:0]   req_a,
  input  logic [4*NREQ-1:0]   req_b,
  input  logic [3*NREQ-1:0]   req_op,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [3:0]          rsp_result,
  output logic                rsp_zero,
  output logic                rsp_carry,
  output logic                busy,
  output logic [7:0]          ops_done
);

  state_t     state, state_nxt;
  op_t        cur;
  logic       last;
  logic       grant;
  logic       hs;
  logic       rsp_done;
  logic [3:0] alu_result;
  logic       alu_zero;
  logic       alu_carry;

  // On a tie the requester not served last wins; otherwise the sole requester.
  always_comb begin
    if (req_valid[0] && req_valid[1]) grant = ~last;
    else                              grant = ~req_valid[0];
  end

  always_comb begin
    req_ready = '0;
    if (state == ST_IDLE && req_valid[grant]) req_ready[grant] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (state == ST_RESP) rsp_valid[cur.owner] = 1'b1;
  end

  assign hs       = |(req_valid & req_ready);
  assign rsp_done = (state == ST_RESP) && rsp_ready[cur.owner];
  assign busy     = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (hs) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (rsp_done) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  ALU_4bit u_alu (
    .a      (cur.a),
    .b      (cur.b),
    .op     (cur.op),
    .result (alu_result),
    .zero   (alu_zero),
    .carry  (alu_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cur        <= '0;
      last       <= 1'b1;
      ops_done   <= 8'd0;
      rsp_result <= 4'd0;
      rsp_zero   <= 1'b0;
      rsp_carry  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        cur.owner <= grant;
        cur.a     <= req_a[4*int'(grant) +: 4];
        cur.b     <= req_b[4*int'(grant) +: 4];
        cur.op    <= req_op[3*int'(grant) +: 3];
      end
      if (state == ST_EXEC) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
        rsp_carry  <= alu_carry;
      end
      // ops_done wraps naturally at 8 bits.
      if (rsp_done) begin
        last     <= cur.owner;
        ops_done <= ops_done + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Bench for alu_arbiter_ctrl: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a transaction-level model.
module tb_alu_arbiter_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0] req_a, req_b;
  logic [5:0] req_op;
  logic [3:0] rsp_result;
  logic       rsp_zero, rsp_carry, busy;
  logic [7:0] ops_done;

  int total = 0;
  int bad   = 0;

  // Model: one in-flight transaction with its age in cycles since acceptance.
  bit m_fly;
  int m_age;
  int m_owner;
  int m_res;
  bit m_z, m_c;
  int m_last;
  int m_ops;
  int x_res;
  bit x_z, x_c;

  alu_arbiter_ctrl #(.NREQ(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_carry  (rsp_carry),
    .busy       (busy),
    .ops_done   (ops_done)
  );

  always #5 clk = ~clk;

  function automatic void ref_alu(input int a, input int b, input int op,
                                  output int r, output bit z, output bit c);
    c = 1'b0;
    case (op)
      0: begin r = (a + b) % 16; c = (a + b) > 15; end
      1: begin r = (a - b + 16) % 16; c = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 15 - a;
      6: r = 15 - (a & b);
      default: r = 15 - (a | b);
    endcase
    z = (r == 0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [1:0] v);
    if (v == 2'b11) return 1 - m_last;
    return v[0] ? 0 : 1;
  endfunction

  task automatic cmp_all();
    logic [1:0] e_rdy, e_vld;
    e_rdy = 2'b00;
    e_vld = 2'b00;
    if (!m_fly && req_valid != 2'b00) e_rdy[pick(req_valid)] = 1'b1;
    if (m_fly && m_age == 2) e_vld[m_owner] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_vld));
    chk("busy", 32'(busy), 32'(m_fly));
    chk("rsp_result", 32'(rsp_result), m_res);
    chk("rsp_zero", 32'(rsp_zero), 32'(m_z));
    chk("rsp_carry", 32'(rsp_carry), 32'(m_c));
    chk("ops_done", 32'(ops_done), m_ops);
  endtask

  task automatic model_step();
    int g;
    if (!m_fly) begin
      if (req_valid != 2'b00) begin
        g = pick(req_valid);
        m_fly = 1'b1;
        m_age = 1;
        m_owner = g;
        ref_alu(int'(req_a[4*g +: 4]), int'(req_b[4*g +: 4]), int'(req_op[3*g +: 3]),
                x_res, x_z, x_c);
      end
    end else if (m_age == 1) begin
      m_age = 2;
      m_res = x_res;
      m_z   = x_z;
      m_c   = x_c;
    end else if (rsp_ready[m_owner]) begin
      m_fly  = 1'b0;
      m_last = m_owner;
      m_ops  = (m_ops + 1) % 256;
    end
  endtask

  // Drive one cycle's inputs at the falling edge, compare, then advance the model.
  task automatic step(input logic [1:0] v, input logic [3:0] a0, input logic [3:0] b0,
                      input logic [2:0] o0, input logic [3:0] a1, input logic [3:0] b1,
                      input logic [2:0] o1, input logic [1:0] rr);
    @(negedge clk);
    req_valid = v;
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    req_op    = {o1, o0};
    rsp_ready = rr;
    #1;
    cmp_all();
    model_step();
  endtask

  task automatic idle(input logic [1:0] rr);
    step(2'b00, 4'd0, 4'd0, 3'd0, 4'd0, 4'd0, 3'd0, rr);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    #1;
    chk({nm, ".rsp_valid"}, 32'(rsp_valid), 0);
    chk({nm, ".req_ready"}, 32'(req_ready), 0);
    chk({nm, ".busy"}, 32'(busy), 0);
    chk({nm, ".result"}, 32'(rsp_result), 0);
    chk({nm, ".zero"}, 32'(rsp_zero), 0);
    chk({nm, ".carry"}, 32'(rsp_carry), 0);
    chk({nm, ".ops_done"}, 32'(ops_done), 0);
    m_fly = 1'b0; m_age = 0; m_owner = 0;
    m_res = 0; m_z = 1'b0; m_c = 1'b0;
    m_last = 1; m_ops = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b00; rsp_ready = 2'b00;
    req_a = 8'd0; req_b = 8'd0; req_op = 6'd0;
    do_reset("reset");

    // Single op: 9 + 8 = 17 -> result 1, carry 1.
    step(2'b01, 4'd9, 4'd8, 3'd0, 4'd0, 4'd0, 3'd0, 2'b00);
    chk("single.accept", 32'(req_ready), 1);
    idle(2'b00);
    chk("single.exec_busy", 32'(busy), 1);
    chk("single.exec_novld", 32'(rsp_valid), 0);
    idle(2'b01);
    chk("single.vld", 32'(rsp_valid), 1);
    chk("single.result", 32'(rsp_result), 1);
    chk("single.carry", 32'(rsp_carry), 1);
    chk("single.zero", 32'(rsp_zero), 0);
    idle(2'b00);
    chk("single.count", 32'(ops_done), 1);

    // Tie after reset: req0 first, then req1, then req0 again.
    do_reset("reset2");
    for (int i = 0; i < 7; i++) begin
      step(2'b11, 4'd3, 4'd3, 3'd1, 4'd5, 4'd10, 3'd2, 2'b11);
      if (i == 0) chk("tie.first", 32'(req_ready), 1);
      if (i == 2) begin
        chk("tie.vld0", 32'(rsp_valid), 1);
        chk("tie.res0", 32'(rsp_result), 0);
        chk("tie.zero0", 32'(rsp_zero), 1);
        chk("tie.carry0", 32'(rsp_carry), 0);
      end
      if (i == 3) chk("tie.second", 32'(req_ready), 2);
      if (i == 5) begin
        chk("tie.vld1", 32'(rsp_valid), 2);
        chk("tie.zero1", 32'(rsp_zero), 1);
      end
      if (i == 6) chk("tie.third", 32'(req_ready), 1);
    end
    for (int i = 0; i < 2; i++) idle(2'b11);

    // Backpressure with a borrowing subtract; req1 waits, its rsp_ready is ignored.
    do_reset("reset3");
    step(2'b01, 4'd2, 4'd5, 3'd1, 4'd0, 4'd0, 3'd0, 2'b00);
    idle(2'b00);
    for (int i = 0; i < 5; i++) begin
      step(2'b10, 4'd0, 4'd0, 3'd0, 4'd15, 4'd6, 3'd5, 2'b10);
      chk("bp.vld", 32'(rsp_valid), 1);
      chk("bp.rdy", 32'(req_ready), 0);
      chk("bp.busy", 32'(busy), 1);
      chk("bp.result", 32'(rsp_result), 13);
      chk("bp.carry", 32'(rsp_carry), 1);
    end
    step(2'b10, 4'd0, 4'd0, 3'd0, 4'd15, 4'd6, 3'd5, 2'b01);
    step(2'b10, 4'd0, 4'd0, 3'd0, 4'd15, 4'd6, 3'd5, 2'b00);
    chk("nota.accept", 32'(req_ready), 2);
    idle(2'b00);
    idle(2'b10);
    chk("nota.result", 32'(rsp_result), 0);
    chk("nota.zero", 32'(rsp_zero), 1);
    chk("nota.carry", 32'(rsp_carry), 0);
    idle(2'b00);

    // Reset during EXEC after a non-zero result is held.
    step(2'b01, 4'd9, 4'd8, 3'd0, 4'd0, 4'd0, 3'd0, 2'b00);
    idle(2'b00);
    idle(2'b01);
    step(2'b01, 4'd7, 4'd1, 3'd3, 4'd0, 4'd0, 3'd0, 2'b00);
    do_reset("midreset");
    for (int i = 0; i < 4; i++) begin
      idle(2'b11);
      chk("midreset.novld", 32'(rsp_valid), 0);
    end

    // 256 back-to-back ops: counter wraps to 0.
    do_reset("reset4");
    for (int i = 0; i < 768; i++)
      step(2'b01, 4'($urandom_range(15)), 4'($urandom_range(15)), 3'($urandom_range(7)),
           4'd0, 4'd0, 3'd0, 2'b01);
    chk("wrap.pre", 32'(ops_done), 255);
    idle(2'b00);
    chk("wrap.zero", 32'(ops_done), 0);

    // Randomized traffic including cancels, ties and backpressure.
    for (int i = 0; i < 3000; i++)
      step(2'($urandom_range(3)), 4'($urandom_range(15)), 4'($urandom_range(15)),
           3'($urandom_range(7)), 4'($urandom_range(15)), 4'($urandom_range(15)),
           3'($urandom_range(7)), 2'($urandom_range(3)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter_ctrl.md
ALU_ARBITER_CTRL -- requirements
Module: alu_arbiter_ctrl

Interface
REQ-001 Parameter: NREQ, default 2, number of requesters; fixed at 2 in this revision.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  [1:0]  per-requester operation request.
REQ-005 req_ready  output  [1:0]  per-requester accept; at most one bit high.
REQ-006 req_a, req_b  input  [7:0] each  packed operands, requester i in bits [4i+3:4i].
REQ-007 req_op  input  [5:0]  packed 3-bit opcodes, requester i in bits [3i+2:3i].
REQ-008 rsp_valid  output  [1:0]  per-requester result valid; at most one bit high.
REQ-009 rsp_ready  input  [1:0]  per-requester result accept.
REQ-010 rsp_result  output  4  registered ALU result, shared by both requesters.
REQ-011 rsp_zero, rsp_carry  output  1 each  registered ALU flags.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 ops_done  output  8  count of completed operations.

Function
REQ-014 FSM states IDLE, EXEC and RESP shall be used; encoding is free.
REQ-015 IDLE: grant = the only valid requester; if both valid, the requester not served last; req_ready[grant] = 1 combinationally, other bit 0.
REQ-016 Handshake (req_valid & req_ready) in IDLE shall latch the operands, opcode and owner index and move the FSM to EXEC.
REQ-017 req_ready shall be 0 in EXEC and RESP.
REQ-018 EXEC: one cycle; ALU driven from latched operands; result, zero and carry registered at end of cycle; FSM moves to RESP.
REQ-019 RESP: rsp_valid[owner] = 1 and outputs held stable until rsp_ready[owner] = 1; then return to IDLE, last-served pointer = owner, ops_done += 1.
REQ-020 rsp_ready on the non-owner bit shall be ignored.
REQ-021 Latency: handshake in cycle N shall produce rsp_valid in cycle N+2; minimum issue interval 3 cycles (accept, EXEC, RESP with rsp_ready=1).
REQ-022 ALU semantics: opcodes 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 NAND, 111 NOR; carry = bit 4 of 5-bit sum/difference for ADD/SUB, 0 otherwise; zero = (result == 0).
REQ-023 SUB carry shall be the borrow bit (A < B gives 1).
REQ-024 ops_done shall wrap 255 -> 0 without saturation or flag.
REQ-025 Dropping req_valid before the handshake shall cancel that request; no state change.
REQ-026 New req_valid arriving during EXEC/RESP shall wait; no queueing beyond the requester holding valid.

Reset
REQ-027 On rst_n low: FSM = IDLE, req_ready/rsp_valid = 0, rsp_result = 0, rsp_zero = 0, rsp_carry = 0, busy = 0, ops_done = 0, last-served pointer = requester 1 (requester 0 wins first tie).
REQ-028 Reset asserted in EXEC or RESP shall discard the in-flight operation; no rsp_valid after release until a new handshake.
REQ-029 First grant may occur in the first clock edge after rst_n deasserts.

Structure
REQ-030 Shared package alu_pkg shall hold the opcode constants and the FSM state typedef.
REQ-031 The combinational ALU shall be a single instantiated sub-module, ALU_4bit; arbitration and FSM stay in this module.

Verification
REQ-032 Single op: req0 A=9 B=8 op=000 -> rsp_valid[0] two cycles after accept, result=1, carry=1, zero=0.
REQ-033 Tie: both valid, req0 A=3 B=3 SUB, req1 A=5 B=A AND, rsp_ready=1 -> req0 served first (result 0, zero=1, carry=0), then req1 (result 0, zero=1), then req0 again if still valid.
REQ-034 Backpressure: rsp_ready[0]=0 for 5 cycles after rsp_valid[0] -> outputs stable, req_ready=00, busy=1; rsp_ready[1]=1 meanwhile has no effect.
REQ-035 Borrow: A=2 B=5 SUB -> result=D, carry=1; NOT A=F -> result=0, zero=1, carry=0.
REQ-036 Reset mid-op: rst_n low in EXEC -> all outputs 0 immediately; after release no rsp_valid without new request.
REQ-037 Wrap: 256 completed ops -> ops_done returns to 0.
